mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 16: datapath word width; only the num_inst width scales with it, unless CNT_W overrides.
REQ-002 Parameter CNT_W, default WORD_SIZE: width of the retired-instruction counter.
REQ-003 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ack; 0 disables timeout.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on posedge.
REQ-006 reset_n  in  1  synchronous, active-high reset; the name is retained, the polarity is high.
REQ-007 opcode  in  4  IR[15:12]; func  in  6  IR[5:0]; bcond  in  1  branch condition from the ALU.
REQ-008 mem_ack  in  1  memory completion, valid for one cycle.
REQ-009 mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, save_alu_out, mem_to_reg, wwd, alu_src_a  out  1  datapath controls.
REQ-010 alu_src_b  out  2  (00 rs, 01 const 1, 10 imm, 11 reserved); pc_src  out  2  (00 alu_result, 01 alu_out, 10 target, 11 rs).
REQ-011 num_inst  out  CNT_W  retired count; state  out  3  current state; halted  out  1; fault  out  1.

Function
REQ-012 States: IF, ID, EX, MEM, WB, HALT, FAULT. All outputs shall be combinational from the state, the decoded class, bcond and mem_ack.
REQ-013 IF: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01. On mem_ack: ir_write=1, pc_write=1, pc_src=00, next state ID; otherwise remain in IF.
REQ-014 ID: the opclass decoder shall map opcode/func to ALU_R, ALU_I, LOAD, STORE, BRANCH, JMP, JAL, JPR, JRL, WWD, HLT or ILLEGAL.
REQ-015 ID exits:
- HLT -> HALT.
- ILLEGAL -> FAULT.
- WWD: wwd=1 for one cycle, then retire -> IF.
- JMP/JAL: pc_write=1, pc_src=10, then retire -> IF. JAL additionally asserts reg_write=1 and mem_to_reg=1 (PC link).
- JPR/JRL: pc_write=1, pc_src=11, then retire -> IF. JRL additionally asserts reg_write=1 and mem_to_reg=1 (PC link).
- All other classes -> EX.
REQ-016 EX: alu_src_a=1; alu_src_b=00 for ALU_R/BRANCH and 10 otherwise; save_alu_out=1.
- BRANCH: pc_write=bcond, pc_src=01, then retire -> IF.
- LOAD/STORE -> MEM.
- ALU_R/ALU_I -> WB.
REQ-017 MEM: mem_req=1, i_or_d=1, mem_we=1 for STORE. On mem_ack: STORE retires -> IF; LOAD -> WB. Otherwise remain in MEM.
REQ-018 WB: reg_write=1 for one cycle, mem_to_reg=1 for LOAD; then retire -> IF.
REQ-019 Retire: num_inst increments by 1 on the edge leaving the retiring state. It wraps modulo 2^CNT_W. HLT does not retire.
REQ-020 Wait counter:
- Clears on entry to IF or MEM.
- Increments each cycle in IF or MEM with mem_req=1 and mem_ack=0.
- If TIMEOUT>0 and the counter reaches TIMEOUT without an ack, next state is FAULT.
- An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal transition, no fault.
REQ-021 HALT: halted=1 and all controls 0; the state is absorbing until reset.
REQ-022 FAULT: fault=1 and all controls 0; the state is absorbing until reset.
REQ-023 mem_ack outside IF/MEM shall be ignored.

Reset
REQ-024 On a clk edge with reset_n=1: state<=IF, num_inst<=0, wait counter<=0. Reset overrides every transition, including in HALT, FAULT or mid-MEM.
REQ-025 While reset_n=1, all outputs shall be forced to 0. state reads IF once the first post-reset edge has occurred.
REQ-026 After reset_n falls, the first fetch (mem_req=1) shall appear in the same cycle.

Structure
REQ-027 Package mc_ctrl_pkg shall hold the state encoding, the opclass enum, and the alu_src_b/pc_src select constants. Opcode/func values come from the existing opcodes definitions.
REQ-028 Sub-module mc_opclass_decode shall be purely combinational: opcode, func -> opclass.
REQ-029 Target size: 150-300 lines of RTL in total.

Verification
REQ-030 ADD (ALU_R), ack in the same cycle as request: state sequence IF,ID,EX,WB,IF; num_inst 0->1 after 4 cycles; reg_write high exactly 1 cycle.
REQ-031 LW with mem_ack delayed 3 cycles in MEM: MEM lasts 4 cycles with mem_req=1, i_or_d=1, mem_we=0; WB has mem_to_reg=1; num_inst +1.
REQ-032 BNE with bcond=0, then with bcond=1: pc_write=0 then 1 in EX, pc_src=01; both retire, num_inst +2.
REQ-033 TIMEOUT=4, no ack in IF: FAULT after 4 wait cycles, fault=1, mem_req=0. Ack arriving on the 4th wait cycle: no fault.
REQ-034 HLT: halted=1 held for 20 cycles, num_inst unchanged. reset_n=1 for 1 cycle then 0: state=IF, num_inst=0, halted=0.
REQ-035 CNT_W=4, 17 WWD instructions: num_inst wraps to 1; wwd pulses 17 times, one cycle each.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// instruction classes, datapath mux selects and the ISA opcode/func values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OC_ALU_R, OC_ALU_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JMP,
    OC_JAL, OC_JPR, OC_JRL, OC_WWD, OC_HLT, OC_ILLEGAL
  } opclass_e;

  localparam logic [1:0] SRCB_RS  = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_TARGET     = 2'b10;
  localparam logic [1:0] PC_RS         = 2'b11;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type func: 0..7 are the ALU operations (ADD..SHR)
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       save_alu_out;
    logic       mem_to_reg;
    logic       wwd;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       halted;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. Memory handshake: mem_req stays high
// while an access is pending; mem_ack is a one-cycle pulse completing it in
// the cycle it is seen, and is ignored unless the sequencer is in IF or MEM.
interface mc_sequencer_if #(parameter int CNT_W = 16);
  logic [3:0]       opcode;
  logic [5:0]       func;
  logic             bcond;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             save_alu_out;
  logic             mem_to_reg;
  logic             wwd;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] num_inst;
  logic [2:0]       state;
  logic             halted;
  logic             fault;

  modport master (
    input  opcode, func, bcond, mem_ack,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write,
           save_alu_out, mem_to_reg, wwd, alu_src_a, alu_src_b, pc_src,
           num_inst, state, halted, fault
  );

  modport slave (
    output opcode, func, bcond, mem_ack,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write,
           save_alu_out, mem_to_reg, wwd, alu_src_a, alu_src_b, pc_src,
           num_inst, state, halted, fault
  );
endinterface

// File: rtl/mc_opclass_decode.sv
// Combinational instruction classifier: opcode/func fields of IR -> opclass.
module mc_opclass_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output opclass_e   opclass
);

  always_comb begin
    opclass = OC_ILLEGAL;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: opclass = OC_BRANCH;
      OP_ADI, OP_ORI, OP_LHI:         opclass = OC_ALU_I;
      OP_LWD:                         opclass = OC_LOAD;
      OP_SWD:                         opclass = OC_STORE;
      OP_JMP:                         opclass = OC_JMP;
      OP_JAL:                         opclass = OC_JAL;
      OP_RTYPE: begin
        if (func <= FN_SHR) opclass = OC_ALU_R;
        else begin
          case (func)
            FN_JPR:  opclass = OC_JPR;
            FN_JRL:  opclass = OC_JRL;
            FN_WWD:  opclass = OC_WWD;
            FN_HLT:  opclass = OC_HLT;
            default: opclass = OC_ILLEGAL;
          endcase
        end
      end
      default: opclass = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) with memory-wait timeout,
// retired-instruction counter and absorbing HALT/FAULT states.
module mc_sequencer
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = WORD_SIZE,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  mc_sequencer_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 2);

  state_e            state_q, state_d;
  opclass_e          opclass;
  ctrl_t             ctl, ctl_out;
  logic              retire;
  logic              waiting;
  logic              timeout_hit;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  num_q;

  mc_opclass_decode u_decode (
    .opcode  (bus.opcode),
    .func    (bus.func),
    .opclass (opclass)
  );

  assign waiting = (state_q == ST_IF) || (state_q == ST_MEM);
  // An ack in the last allowed cycle beats the timeout.
  assign timeout_hit = (TIMEOUT > 0) && waiting && !bus.mem_ack &&
                       (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    ctl     = '0;
    case (state_q)
      ST_IF: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        if (bus.mem_ack) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_ALU_RESULT;
          state_d      = ST_ID;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_ID: begin
        case (opclass)
          OC_HLT:     state_d = ST_HALT;
          OC_ILLEGAL: state_d = ST_FAULT;
          OC_WWD: begin
            ctl.wwd = 1'b1;
            retire  = 1'b1;
            state_d = ST_IF;
          end
          OC_JMP, OC_JAL, OC_JPR, OC_JRL: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_src     = (opclass == OC_JMP || opclass == OC_JAL) ? PC_TARGET : PC_RS;
            ctl.reg_write  = (opclass == OC_JAL || opclass == OC_JRL);
            ctl.mem_to_reg = (opclass == OC_JAL || opclass == OC_JRL);
            retire         = 1'b1;
            state_d        = ST_IF;
          end
          default: state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = (opclass == OC_ALU_R || opclass == OC_BRANCH) ? SRCB_RS : SRCB_IMM;
        ctl.save_alu_out = 1'b1;
        if (opclass == OC_BRANCH) begin
          ctl.pc_write = bus.bcond;
          ctl.pc_src   = PC_ALU_OUT;
          retire       = 1'b1;
          state_d      = ST_IF;
        end else if (opclass == OC_LOAD || opclass == OC_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.i_or_d  = 1'b1;
        ctl.mem_we  = (opclass == OC_STORE);
        if (bus.mem_ack) begin
          retire  = (opclass == OC_STORE);
          state_d = (opclass == OC_STORE) ? ST_IF : ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = (opclass == OC_LOAD);
        retire         = 1'b1;
        state_d        = ST_IF;
      end
      ST_HALT:  ctl.halted = 1'b1;
      ST_FAULT: ctl.fault  = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= ST_IF;
      num_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (retire) num_q <= num_q + CNT_W'(1);
      if (state_d != state_q) wait_q <= '0;
      else if (waiting && !bus.mem_ack) wait_q <= wait_q + WAIT_W'(1);
    end
  end

  assign ctl_out = reset_n ? '0 : ctl;

  assign bus.mem_req      = ctl_out.mem_req;
  assign bus.mem_we       = ctl_out.mem_we;
  assign bus.i_or_d       = ctl_out.i_or_d;
  assign bus.ir_write     = ctl_out.ir_write;
  assign bus.pc_write     = ctl_out.pc_write;
  assign bus.reg_write    = ctl_out.reg_write;
  assign bus.save_alu_out = ctl_out.save_alu_out;
  assign bus.mem_to_reg   = ctl_out.mem_to_reg;
  assign bus.wwd          = ctl_out.wwd;
  assign bus.alu_src_a    = ctl_out.alu_src_a;
  assign bus.alu_src_b    = ctl_out.alu_src_b;
  assign bus.pc_src       = ctl_out.pc_src;
  assign bus.halted       = ctl_out.halted;
  assign bus.fault        = ctl_out.fault;
  assign bus.num_inst     = reset_n ? '0 : num_q;
  assign bus.state        = reset_n ? ST_IF : state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction expected state sequences are queued
// from a small bench model and compared cycle by cycle against a trace.
module tb_mc_sequencer;
  import mc_ctrl_pkg::*;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_ID    = 4;  // retires from ID (WWD, jumps)
  localparam int K_STOP  = 5;  // HLT / illegal: never retires

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  mc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  mc_sequencer #(.WORD_SIZE(16), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int               tests_run = 0;
  int               tests_failed = 0;
  logic [CNT_W-1:0] exp_num = '0;
  logic [2:0]       exp_q[$];
  logic             ack_q[$];
  logic [2:0]       t_state [64];
  ctrl_t            t_ctl [64];
  int               t_len;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset_n = 1'b1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_num = '0;
  endtask

  // Queue the model's state sequence, drive acks on schedule, record a trace.
  task automatic drive_instr(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                             input int kind, input int if_wait, input int mem_wait);
    exp_q.delete();
    ack_q.delete();
    for (int i = 0; i <= if_wait; i++) begin
      exp_q.push_back(ST_IF);
      ack_q.push_back(i == if_wait);
    end
    exp_q.push_back(ST_ID); ack_q.push_back(1'b0);
    if (kind <= K_BR) begin exp_q.push_back(ST_EX); ack_q.push_back(1'b0); end
    if (kind == K_LOAD || kind == K_STORE)
      for (int i = 0; i <= mem_wait; i++) begin
        exp_q.push_back(ST_MEM);
        ack_q.push_back(i == mem_wait);
      end
    if (kind == K_LOAD || kind == K_ALU) begin exp_q.push_back(ST_WB); ack_q.push_back(1'b0); end
    t_len = exp_q.size();
    bus.opcode = op; bus.func = fn; bus.bcond = bc;
    for (int i = 0; i < t_len; i++) begin
      bus.mem_ack = ack_q[i];
      #1;
      t_state[i] = bus.state;
      t_ctl[i] = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.save_alu_out, bus.mem_to_reg, bus.wwd,
                  bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.halted, bus.fault};
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    if (kind != K_STOP) exp_num = exp_num + 1'b1;
  endtask

  task automatic test_reset();
    bus.opcode = OP_RTYPE; bus.func = FN_HLT; bus.bcond = 1'b1; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.halted, bus.fault} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctl: got %b required 00000",
        {bus.mem_req, bus.ir_write, bus.pc_write, bus.halted, bus.fault});
    end
    tests_run++;
    if (bus.num_inst !== '0 || bus.state !== 3'd0) begin
      tests_failed++; $display("FAIL reset_num_state: got %0d/%0d required 0/0", bus.num_inst, bus.state);
    end
    @(posedge clk); #1;
    reset_n = 1'b0; bus.mem_ack = 1'b0; exp_num = '0;
    #1;
    tests_run++;
    if ({bus.mem_req, bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.state} !== {3'b100, 2'b01, 3'd0}) begin
      tests_failed++; $display("FAIL first_fetch: got req=%b iod=%b srca=%b srcb=%b st=%0d required 1 0 0 01 0",
        bus.mem_req, bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.state);
    end
  endtask

  task automatic test_alu_r();
    int rw;
    logic [2:0] e;
    drive_instr(OP_RTYPE, 6'd0, 1'b0, K_ALU, 0, 0);
    rw = 0;
    for (int i = 0; i < t_len; i++) begin
      e = exp_q.pop_front();
      rw += int'(t_ctl[i].reg_write);
      tests_run++;
      if (t_state[i] !== e) begin tests_failed++; $display("FAIL add_seq[%0d]: got %0d required %0d", i, t_state[i], e); end
    end
    tests_run++;
    if (rw != 1 || t_ctl[3].reg_write !== 1'b1) begin tests_failed++; $display("FAIL add_reg_write: got %0d cycles required 1 in WB", rw); end
    tests_run++;
    if ({t_ctl[0].ir_write, t_ctl[0].pc_write, t_ctl[0].pc_src} !== 4'b1100) begin
      tests_failed++; $display("FAIL if_ack_ctl: got %b required 1100", {t_ctl[0].ir_write, t_ctl[0].pc_write, t_ctl[0].pc_src});
    end
    tests_run++;
    if ({t_ctl[2].alu_src_a, t_ctl[2].alu_src_b, t_ctl[2].save_alu_out} !== 4'b1001) begin
      tests_failed++; $display("FAIL add_ex_ctl: got %b required 1001", {t_ctl[2].alu_src_a, t_ctl[2].alu_src_b, t_ctl[2].save_alu_out});
    end
    tests_run++;
    if (bus.num_inst !== exp_num) begin tests_failed++; $display("FAIL add_num: got %0d required %0d", bus.num_inst, exp_num); end
  endtask

  task automatic test_load();
    int ok;
    logic [2:0] e;
    drive_instr(OP_LWD, 6'd0, 1'b0, K_LOAD, 0, 3);
    for (int i = 0; i < t_len; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (t_state[i] !== e) begin tests_failed++; $display("FAIL lw_seq[%0d]: got %0d required %0d", i, t_state[i], e); end
    end
    ok = 0;
    for (int i = 3; i <= 6; i++)
      if ({t_ctl[i].mem_req, t_ctl[i].i_or_d, t_ctl[i].mem_we} === 3'b110) ok++;
    tests_run++;
    if (ok != 4) begin tests_failed++; $display("FAIL lw_mem_ctl: got %0d good cycles required 4", ok); end
    tests_run++;
    if ({t_ctl[7].reg_write, t_ctl[7].mem_to_reg, t_ctl[2].alu_src_b} !== 4'b1110) begin
      tests_failed++; $display("FAIL lw_wb_ex: got %b required 1110", {t_ctl[7].reg_write, t_ctl[7].mem_to_reg, t_ctl[2].alu_src_b});
    end
    tests_run++;
    if (bus.num_inst !== exp_num) begin tests_failed++; $display("FAIL lw_num: got %0d required %0d", bus.num_inst, exp_num); end
  endtask

  task automatic test_branch();
    logic [2:0] e;
    for (int b = 0; b < 2; b++) begin
      drive_instr(OP_BNE, 6'd0, 1'(b), K_BR, 0, 0);
      for (int i = 0; i < t_len; i++) begin
        e = exp_q.pop_front();
        tests_run++;
        if (t_state[i] !== e) begin tests_failed++; $display("FAIL bne_seq[%0d]: got %0d required %0d", i, t_state[i], e); end
      end
      tests_run++;
      if ({t_ctl[2].pc_write, t_ctl[2].pc_src, t_ctl[2].alu_src_b} !== {1'(b), 2'b01, 2'b00}) begin
        tests_failed++; $display("FAIL bne_ex_ctl: got %b required %b",
          {t_ctl[2].pc_write, t_ctl[2].pc_src, t_ctl[2].alu_src_b}, {1'(b), 2'b01, 2'b00});
      end
    end
    tests_run++;
    if (bus.num_inst !== exp_num) begin tests_failed++; $display("FAIL bne_num: got %0d required %0d", bus.num_inst, exp_num); end
  endtask

  task automatic test_jumps();
    logic [3:0] ops [3] = '{OP_JAL, OP_RTYPE, OP_RTYPE};
    logic [5:0] fns [3] = '{6'd0, FN_JRL, FN_JPR};
    logic [4:0] req [3] = '{5'b11011, 5'b11111, 5'b11100};
    logic [2:0] e;
    for (int j = 0; j < 3; j++) begin
      drive_instr(ops[j], fns[j], 1'b0, K_ID, 1, 0);
      e = exp_q.pop_back();
      tests_run++;
      if (t_state[t_len-1] !== e) begin tests_failed++; $display("FAIL jump_state[%0d]: got %0d required %0d", j, t_state[t_len-1], e); end
      tests_run++;
      if ({t_ctl[2].pc_write, t_ctl[2].pc_src, t_ctl[2].reg_write, t_ctl[2].mem_to_reg} !== req[j]) begin
        tests_failed++; $display("FAIL jump_ctl[%0d]: got %b required %b", j,
          {t_ctl[2].pc_write, t_ctl[2].pc_src, t_ctl[2].reg_write, t_ctl[2].mem_to_reg}, req[j]);
      end
    end
    drive_instr(OP_SWD, 6'd0, 1'b0, K_STORE, 0, 1);
    for (int i = 0; i < t_len; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (t_state[i] !== e) begin tests_failed++; $display("FAIL sw_seq[%0d]: got %0d required %0d", i, t_state[i], e); end
    end
    tests_run++;
    if ({t_ctl[3].mem_we, t_ctl[4].mem_we, t_ctl[4].i_or_d} !== 3'b111) begin
      tests_failed++; $display("FAIL sw_mem_we: got %b required 111", {t_ctl[3].mem_we, t_ctl[4].mem_we, t_ctl[4].i_or_d});
    end
    tests_run++;
    if (bus.num_inst !== exp_num) begin tests_failed++; $display("FAIL jump_num: got %0d required %0d", bus.num_inst, exp_num); end
  endtask

  task automatic test_timeout();
    int ok;
    logic [2:0] e;
    drive_instr(OP_RTYPE, 6'd1, 1'b0, K_ALU, TIMEOUT - 1, 0);
    for (int i = 0; i < t_len; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (t_state[i] !== e) begin tests_failed++; $display("FAIL late_ack_seq[%0d]: got %0d required %0d", i, t_state[i], e); end
    end
    bus.mem_ack = 1'b0;
    ok = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      if (bus.state === 3'(ST_IF) && bus.mem_req === 1'b1) ok++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (ok != TIMEOUT) begin tests_failed++; $display("FAIL wait_cycles: got %0d required %0d", ok, TIMEOUT); end
    tests_run++;
    if ({bus.state, bus.fault, bus.mem_req} !== {3'(ST_FAULT), 2'b10}) begin
      tests_failed++; $display("FAIL timeout_fault: got st=%0d fault=%b req=%b required 6 1 0", bus.state, bus.fault, bus.mem_req);
    end
    bus.mem_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ack = 1'b0;
    tests_run++;
    if (bus.state !== 3'(ST_FAULT) || bus.num_inst !== exp_num) begin
      tests_failed++; $display("FAIL fault_absorb: got st=%0d num=%0d required 6 %0d", bus.state, bus.num_inst, exp_num);
    end
    apply_reset();
    #1;
    tests_run++;
    if ({bus.state, bus.fault, bus.num_inst} !== {3'd0, 1'b0, 4'd0}) begin
      tests_failed++; $display("FAIL fault_reset: got st=%0d fault=%b num=%0d required 0 0 0", bus.state, bus.fault, bus.num_inst);
    end
  endtask

  task automatic test_halt();
    int ok;
    drive_instr(OP_RTYPE, FN_HLT, 1'b0, K_STOP, 0, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (bus.state === 3'(ST_HALT) && bus.halted === 1'b1 && bus.mem_req === 1'b0 && bus.num_inst === exp_num) ok++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (ok != 20) begin tests_failed++; $display("FAIL halt_hold: got %0d good cycles required 20", ok); end
    apply_reset();
    #1;
    tests_run++;
    if ({bus.state, bus.halted, bus.num_inst} !== {3'd0, 1'b0, 4'd0}) begin
      tests_failed++; $display("FAIL halt_reset: got st=%0d halted=%b num=%0d required 0 0 0", bus.state, bus.halted, bus.num_inst);
    end
    drive_instr(4'd12, 6'd0, 1'b0, K_STOP, 0, 0);
    tests_run++;
    if ({bus.state, bus.fault, bus.num_inst} !== {3'(ST_FAULT), 1'b1, 4'd0}) begin
      tests_failed++; $display("FAIL illegal: got st=%0d fault=%b num=%0d required 6 1 0", bus.state, bus.fault, bus.num_inst);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    int pulses, bad, w;
    logic [2:0] e;
    pulses = 0; bad = 0;
    for (int n = 0; n < 17; n++) begin
      w = $urandom_range(0, 2);
      drive_instr(OP_RTYPE, FN_WWD, 1'b0, K_ID, w, 0);
      for (int i = 0; i < t_len; i++) begin
        e = exp_q.pop_front();
        pulses += int'(t_ctl[i].wwd);
        if (t_ctl[i].wwd !== (i == w + 1)) bad++;
        tests_run++;
        if (t_state[i] !== e) begin tests_failed++; $display("FAIL wwd_seq[%0d.%0d]: got %0d required %0d", n, i, t_state[i], e); end
      end
    end
    tests_run++;
    if (pulses != 17 || bad != 0) begin tests_failed++; $display("FAIL wwd_pulses: got %0d pulses %0d misplaced required 17 0", pulses, bad); end
    tests_run++;
    if (bus.num_inst !== exp_num || exp_num !== 4'd1) begin
      tests_failed++; $display("FAIL wrap_num: got %0d required 1", bus.num_inst);
    end
  endtask

  initial begin
    bus.opcode = '0; bus.func = '0; bus.bcond = 1'b0; bus.mem_ack = 1'b0;
    test_reset();
    test_alu_r();
    test_load();
    test_branch();
    test_jumps();
    test_timeout();
    test_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
